// File: rtl/squash_verdict_mailbox_if.sv
// Verdict, mailbox-pop and statistics signals between worm_squasher, the CPU
// clients and squash_verdict_mailbox.
// valid_i is a one-cycle strobe with no back-pressure. The upstream arbiter
// must respect full_o, and the mailbox drops a verdict pushed into a full
// mailbox without a same-cycle pop. rd_i[k] pops only when rdy_o[k] is set.
interface squash_verdict_mailbox_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int CID_W       = 2,
  parameter int CNT_W       = 16
);
  logic                   valid_i;
  logic                   match_i;
  logic [CID_W-1:0]       clientid_i;
  logic [NUM_CLIENTS-1:0] rd_i;
  logic [NUM_CLIENTS-1:0] rdy_o;
  logic [NUM_CLIENTS-1:0] verdict_o;
  logic [NUM_CLIENTS-1:0] full_o;
  logic [NUM_CLIENTS-1:0] ovf_o;
  logic [CID_W-1:0]       cnt_sel_i;
  logic [CNT_W-1:0]       pkt_cnt_o;
  logic [CNT_W-1:0]       match_cnt_o;
  logic                   clr_i;

  modport master (
    output valid_i, match_i, clientid_i, rd_i, cnt_sel_i, clr_i,
    input  rdy_o, verdict_o, full_o, ovf_o, pkt_cnt_o, match_cnt_o
  );

  modport slave (
    input  valid_i, match_i, clientid_i, rd_i, cnt_sel_i, clr_i,
    output rdy_o, verdict_o, full_o, ovf_o, pkt_cnt_o, match_cnt_o
  );
endinterface

// File: rtl/squash_verdict_mailbox.sv
// Per-client 2-entry verdict mailboxes with sticky overflow flags and
// saturating packet/match statistics counters.
module squash_verdict_mailbox #(
  parameter int NUM_CLIENTS = 4,
  parameter int CID_W       = 2,
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  squash_verdict_mailbox_if.slave   bus
);
  localparam logic [1:0] LP_FULL = 2'(DEPTH);

  logic [NUM_CLIENTS-1:0] w_rdy;
  logic [NUM_CLIENTS-1:0] w_verdict;
  logic [NUM_CLIENTS-1:0] w_full;
  logic [NUM_CLIENTS-1:0] w_ovf;
  logic [CNT_W-1:0]       w_pkt_cnt   [NUM_CLIENTS];
  logic [CNT_W-1:0]       w_match_cnt [NUM_CLIENTS];

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
    logic [1:0]       r_mem;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             r_ovf;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_match_cnt;

    logic w_push;
    logic w_pop;
    logic w_is_full;
    logic w_accept;

    assign w_push    = bus.valid_i && (bus.clientid_i == CID_W'(k));
    assign w_pop     = bus.rd_i[k] && (r_count != 2'd0);
    assign w_is_full = (r_count == LP_FULL);
    // A pop in the same cycle frees the slot the push needs.
    assign w_accept  = w_push && (!w_is_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_mem    <= 2'b00;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_accept) begin
          r_mem[r_wr_ptr] <= bus.match_i;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_ovf       <= 1'b0;
        r_pkt_cnt   <= '0;
        r_match_cnt <= '0;
      end else if (bus.clr_i) begin
        r_ovf       <= 1'b0;
        r_pkt_cnt   <= '0;
        r_match_cnt <= '0;
      end else begin
        if (w_push && w_is_full && !w_pop) begin
          r_ovf <= 1'b1;
        end
        // Dropped verdicts still count as received packets.
        if (w_push && (r_pkt_cnt != '1)) begin
          r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
        if (w_push && bus.match_i && (r_match_cnt != '1)) begin
          r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
      end
    end

    assign w_rdy[k]       = (r_count != 2'd0);
    assign w_verdict[k]   = (r_count != 2'd0) ? r_mem[r_rd_ptr] : 1'b0;
    assign w_full[k]      = w_is_full;
    assign w_ovf[k]       = r_ovf;
    assign w_pkt_cnt[k]   = r_pkt_cnt;
    assign w_match_cnt[k] = r_match_cnt;
  end

  assign bus.rdy_o       = w_rdy;
  assign bus.verdict_o   = w_verdict;
  assign bus.full_o      = w_full;
  assign bus.ovf_o       = w_ovf;
  assign bus.pkt_cnt_o   = w_pkt_cnt[bus.cnt_sel_i];
  assign bus.match_cnt_o = w_match_cnt[bus.cnt_sel_i];
endmodule

// File: tb/tb_squash_verdict_mailbox.sv
// Directed bench for squash_verdict_mailbox: expected pop results are queued
// at stimulus time and checked by an independent pop monitor.
`timescale 1ns/100ps
module tb_squash_verdict_mailbox;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int NW = 4;

  logic clk_i;
  logic rst_i;

  squash_verdict_mailbox_if #(.NUM_CLIENTS(NC), .CID_W(CW), .CNT_W(NW)) bus ();

  squash_verdict_mailbox #(
    .NUM_CLIENTS(NC), .CID_W(CW), .CNT_W(NW), .DEPTH(2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Clock / reset.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is {client, verdict} in the order pops will occur.
  logic [CW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input int k, input logic [NW-1:0] pkt, input logic [NW-1:0] mat);
    bus.cnt_sel_i = CW'(k);
    #0.2;
    check($sformatf("pkt_cnt[%0d]", k), 32'(bus.pkt_cnt_o), 32'(pkt));
    check($sformatf("match_cnt[%0d]", k), 32'(bus.match_cnt_o), 32'(mat));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_i    = 1'b0;
    bus.match_i    = 1'b0;
    bus.clientid_i = '0;
    bus.rd_i       = '0;
    bus.clr_i      = 1'b0;
  endtask

  task automatic push(input int k, input logic m, input logic expect_pop);
    if (expect_pop) exp_q.push_back({CW'(k), m});
    bus.valid_i    = 1'b1;
    bus.clientid_i = CW'(k);
    bus.match_i    = m;
    step();
    idle_inputs();
  endtask

  task automatic pop(input int k);
    bus.rd_i = NC'(1) << k;
    step();
    idle_inputs();
  endtask

  // Pop monitor: a pop takes effect when rd_i and rdy_o coincide.
  always @(negedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NC; k++) begin
        if (bus.rd_i[k] && bus.rdy_o[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: client %0d popped verdict %0b, expected no pop", k, bus.verdict_o[k]);
          end else begin
            logic [CW:0] e;
            e = exp_q.pop_front();
            if ({CW'(k), bus.verdict_o[k]} !== e) begin
              n_fail++;
              $display("FAIL pop_verdict: got client %0d verdict %0b, expected client %0d verdict %0b",
                       k, bus.verdict_o[k], e[CW:1], e[0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.cnt_sel_i = '0;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    step();

    // Reset state.
    check("reset_rdy", 32'(bus.rdy_o), 32'h0);
    check("reset_full", 32'(bus.full_o), 32'h0);
    check("reset_ovf", 32'(bus.ovf_o), 32'h0);
    check("reset_verdict", 32'(bus.verdict_o), 32'h0);
    for (int k = 0; k < NC; k++) check_cnt(k, 4'd0, 4'd0);

    // Single push and pop.
    push(1, 1'b1, 1'b1);
    check("single_rdy", 32'(bus.rdy_o), 32'b0010);
    check("single_verdict", 32'(bus.verdict_o), 32'b0010);
    check_cnt(1, 4'd1, 4'd1);
    pop(1);
    check("single_rdy_after_pop", 32'(bus.rdy_o), 32'b0000);

    // Fill and overflow on client 2.
    push(2, 1'b0, 1'b1);
    check("fill_full_1st", 32'(bus.full_o), 32'b0000);
    push(2, 1'b1, 1'b1);
    check("fill_full_2nd", 32'(bus.full_o), 32'b0100);
    check("fill_ovf_2nd", 32'(bus.ovf_o), 32'b0000);
    push(2, 1'b1, 1'b0);
    check("ovf_set", 32'(bus.ovf_o), 32'b0100);
    check("ovf_full", 32'(bus.full_o), 32'b0100);
    check("ovf_head", 32'(bus.verdict_o), 32'b0000);
    check_cnt(2, 4'd3, 4'd2);
    pop(2);
    pop(2);
    check("ovf_drained", 32'(bus.rdy_o), 32'b0000);

    // Push and pop together on an empty mailbox: the pop is ignored.
    bus.valid_i = 1'b1; bus.clientid_i = 2'd1; bus.match_i = 1'b0; bus.rd_i = 4'b0010;
    exp_q.push_back({2'd1, 1'b0});
    step();
    idle_inputs();
    check("empty_pushpop_rdy", 32'(bus.rdy_o), 32'b0010);
    pop(1);

    // Push and pop together on a full mailbox: no overflow.
    push(0, 1'b1, 1'b1);
    push(0, 1'b0, 1'b1);
    check("full0_full", 32'(bus.full_o), 32'b0001);
    exp_q.push_back({2'd0, 1'b1});
    bus.valid_i = 1'b1; bus.clientid_i = 2'd0; bus.match_i = 1'b1; bus.rd_i = 4'b0001;
    step();
    idle_inputs();
    check("full_pushpop_ovf", 32'(bus.ovf_o), 32'b0100);
    check("full_pushpop_full", 32'(bus.full_o), 32'b0001);
    check("full_pushpop_head", 32'(bus.verdict_o), 32'b0000);
    pop(0);
    pop(0);
    check("full0_drained", 32'(bus.rdy_o), 32'b0000);

    // Counter saturation on client 3.
    for (int i = 0; i < 20; i++) begin
      push(3, 1'b1, 1'b1);
      pop(3);
    end
    check_cnt(3, 4'd15, 4'd15);

    // Clear coincident with a verdict: counters clear, verdict still queued.
    exp_q.push_back({2'd3, 1'b0});
    bus.valid_i = 1'b1; bus.clientid_i = 2'd3; bus.match_i = 1'b0; bus.clr_i = 1'b1;
    step();
    idle_inputs();
    check_cnt(3, 4'd0, 4'd0);
    check_cnt(2, 4'd0, 4'd0);
    check("clr_ovf", 32'(bus.ovf_o), 32'b0000);
    check("clr_rdy", 32'(bus.rdy_o), 32'b1000);
    pop(3);

    // Pops on empty mailboxes are ignored.
    bus.rd_i = 4'b1111;
    step();
    idle_inputs();
    check("empty_pop_rdy", 32'(bus.rdy_o), 32'b0000);
    check("empty_pop_ovf", 32'(bus.ovf_o), 32'b0000);

    // Asynchronous reset between clock edges discards queued verdicts.
    push(1, 1'b1, 1'b0);
    push(1, 1'b0, 1'b0);
    check("pre_reset_full", 32'(bus.full_o), 32'b0010);
    #2 rst_i = 1'b0;
    #1;
    check("async_rdy", 32'(bus.rdy_o), 32'b0000);
    check("async_full", 32'(bus.full_o), 32'b0000);
    check_cnt(1, 4'd0, 4'd0);
    repeat (2) step();
    rst_i = 1'b1;
    step();
    check("post_reset_rdy", 32'(bus.rdy_o), 32'b0000);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/squash_verdict_mailbox.md
Name: squash_verdict_mailbox

Overview:
Downstream consumer of worm_squasher results. Captures each (valid_o, match_o, clientid_o) verdict into a per-client 2-entry FIFO mailbox, where the owning CPU core reads it with a pop strobe. Keeps per-client saturating packet and match counters for software statistics. Exports per-client full flags so the upstream request arbiter withholds new requests from a client whose mailbox is full.

Parameters:
NUM_CLIENTS, 4, number of CPU clients; must equal 2**CID_W
CID_W, 2, width of client id
CNT_W, 16, width of each statistics counter
DEPTH, 2, mailbox entries per client; fixed at 2, pointers are 1 bit

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  verdict strobe from worm_squasher, one cycle per verdict
match_i  in  1  1 = signature hit (drop), 0 = clean (forward); qualified by valid_i
clientid_i  in  CID_W  client owning the verdict; qualified by valid_i
rd_i  in  NUM_CLIENTS  per-client pop strobe
rdy_o  out  NUM_CLIENTS  per-client mailbox non-empty
verdict_o  out  NUM_CLIENTS  per-client head-entry verdict; 0 when empty
full_o  out  NUM_CLIENTS  per-client mailbox holds DEPTH entries
ovf_o  out  NUM_CLIENTS  sticky per-client overflow
cnt_sel_i  in  CID_W  selects the client shown on the counter outputs
pkt_cnt_o  out  CNT_W  verdicts received for cnt_sel_i
match_cnt_o  out  CNT_W  matches received for cnt_sel_i
clr_i  in  1  synchronous clear of all counters and ovf_o

Behaviour:
- Reset (rst_i=0, asynchronous): all FIFOs empty; rdy_o=0, verdict_o=0, full_o=0, ovf_o=0; all counters 0. Reset mid-operation discards queued verdicts immediately.
- Push: at the edge where valid_i=1, match_i is written to FIFO[clientid_i]. rdy_o/verdict_o/full_o reflect the push from the following cycle (1-cycle latency).
- Pop: at an edge with rd_i[k]=1 and FIFO k non-empty, the head entry is removed. rd_i[k] on an empty FIFO is ignored and causes no error.
- Simultaneous push and pop, same client:
  - Non-empty: both take effect; occupancy unchanged.
  - Empty: the push takes effect and the pop is ignored, because the pop sees the pre-edge empty state.
  - Full: the pop frees one entry, the push is accepted, and there is no overflow.
- Overflow: push to a full FIFO without a same-cycle pop drops the new verdict. The stored entries are unchanged and ovf_o[k] is set and held until clr_i or reset.
- Each FIFO is a 2-entry circular buffer with 1-bit rd/wr pointers and a 2-bit count; pointers wrap 1→0.
- verdict_o[k] = head entry when count>0, else 0.
- full_o[k] = (count==2); combinational from registered state.
- Counters:
  - On valid_i, pkt_cnt[clientid_i] += 1, including dropped (overflowed) verdicts.
  - If match_i is also 1, match_cnt[clientid_i] += 1.
  - Both saturate at 2**CNT_W-1 and do not wrap.
- clr_i: at the edge, all counters and ovf_o are cleared. clr_i has priority over a coincident valid_i for counters and ovf only; the verdict is still pushed.
- Counter outputs: pkt_cnt_o/match_cnt_o are a combinational mux of the registered counters indexed by cnt_sel_i.
- Verdicts for different clients are fully independent. Only one push per cycle is possible because there is a single verdict input.

Test Plan:
- Reset then idle: rst_i=0 for 5 cycles, release → rdy_o=0000, full_o=0000, ovf_o=0000, pkt_cnt_o=0 for all cnt_sel_i.
- Single push/pop: valid_i=1, clientid_i=1, match_i=1 → next cycle rdy_o=0010, verdict_o[1]=1, pkt_cnt(1)=1, match_cnt(1)=1. Pulse rd_i=0010 → rdy_o=0000 next cycle.
- Fill and overflow: push client 2 verdicts 0,1,1 on consecutive cycles with no reads → full_o[2]=1 after the 2nd push, ovf_o[2]=1 after the 3rd, pkt_cnt(2)=3. Reads return 0 then 1, then rdy_o[2]=0.
- Full with simultaneous push+pop: client 0 full with {1,0}; push 1 with rd_i[0]=1 → ovf_o[0] stays 0. Subsequent reads return 0 then 1.
- Saturation and clear: with CNT_W=4, issue 20 matching verdicts to client 3 with reads interleaved → pkt_cnt(3)=match_cnt(3)=15. clr_i coincident with a valid_i for client 3 → counters 0 and the verdict is still queued.
- Async reset mid-traffic: assert rst_i between clock edges while client 1 holds 2 entries → rdy_o and full_o go 0 without waiting for a clock edge.
